// File: rtl/btn_debounce.sv
// btn_debounce: per-button 2-flop synchroniser, counter-based debounce, press/release pulses.
// Sticky press flags and btn_irq are compiled in only when BTN_STICKY_EN is defined.
module btn_debounce #(
  parameter int N_BTN       = 5,
  parameter int DB_CYCLES   = 20000,
  parameter int ACTIVE_HIGH = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [N_BTN-1:0] clr,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_sticky,
  output logic             btn_irq
);

  localparam int CW = ($clog2(DB_CYCLES) < 1) ? 1 : $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  logic [N_BTN-1:0] w_raw;
  logic [N_BTN-1:0] r_sync1;
  logic [N_BTN-1:0] r_sync2;
  logic [N_BTN-1:0] r_stable;
  logic [N_BTN-1:0] r_press;
  logic [N_BTN-1:0] r_release;
  logic [N_BTN-1:0] w_accept;

  // Normalise polarity before the synchroniser so everything downstream is 1 = pressed.
  assign w_raw = (ACTIVE_HIGH != 0) ? btn_raw : ~btn_raw;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_BTN; gi++) begin : g_bit
      logic [CW-1:0] r_cnt;
      logic          w_diff;

      assign w_diff       = r_sync2[gi] ^ r_stable[gi];
      assign w_accept[gi] = w_diff && (r_cnt == CNT_MAX);

      // Any return to the stable level restarts the count, which rejects short glitches.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          r_cnt <= '0;
        end else if (!w_diff || w_accept[gi]) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stable  <= '0;
      r_press   <= '0;
      r_release <= '0;
    end else begin
      r_stable  <= r_stable ^ w_accept;
      r_press   <= w_accept & r_sync2;
      r_release <= w_accept & ~r_sync2;
    end
  end

  assign btn_level   = r_stable;
  assign btn_press   = r_press;
  assign btn_release = r_release;

`ifdef BTN_STICKY_EN
  logic [N_BTN-1:0] r_sticky;

  // Set has priority over a coincident clear so a fresh press is never lost.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sticky <= '0;
    end else begin
      r_sticky <= (r_sticky & ~clr) | (w_accept & r_sync2);
    end
  end

  assign btn_sticky = r_sticky;
  assign btn_irq    = |r_sticky;
`else
  logic w_unused_clr;

  assign w_unused_clr = ^clr;
  assign btn_sticky   = '0;
  assign btn_irq      = 1'b0;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with DB_CYCLES=4: one active-high and one active-low instance.
module tb_btn_debounce;

`ifdef BTN_STICKY_EN
  localparam logic [4:0] SMASK = 5'b11111;
`else
  localparam logic [4:0] SMASK = 5'b00000;
`endif

  logic       clk;
  logic       rstn;
  logic [4:0] raw, clr, level, press, rel, sticky;
  logic       irq;
  logic [4:0] raw_n, clr_n, level_n, press_n, rel_n, sticky_n;
  logic       irq_n;

  int n_checks;
  int n_fail;

  btn_debounce #(.N_BTN(5), .DB_CYCLES(4), .ACTIVE_HIGH(1)) dut (
    .clk(clk), .rstn(rstn), .btn_raw(raw), .clr(clr),
    .btn_level(level), .btn_press(press), .btn_release(rel),
    .btn_sticky(sticky), .btn_irq(irq)
  );

  btn_debounce #(.N_BTN(5), .DB_CYCLES(4), .ACTIVE_HIGH(0)) dut_n (
    .clk(clk), .rstn(rstn), .btn_raw(raw_n), .clr(clr_n),
    .btn_level(level_n), .btn_press(press_n), .btn_release(rel_n),
    .btn_sticky(sticky_n), .btn_irq(irq_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and land on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (level !== 5'b0) begin n_fail++; $display("FAIL reset_level: got %b expected 00000", level); end
    n_checks++; if (press !== 5'b0) begin n_fail++; $display("FAIL reset_press: got %b expected 00000", press); end
    n_checks++; if (rel !== 5'b0) begin n_fail++; $display("FAIL reset_release: got %b expected 00000", rel); end
    n_checks++; if (sticky !== 5'b0) begin n_fail++; $display("FAIL reset_sticky: got %b expected 00000", sticky); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq); end
    n_checks++; if (level_n !== 5'b0) begin n_fail++; $display("FAIL reset_level_n: got %b expected 00000", level_n); end
    rstn = 1'b1;
    repeat (3) step();
    n_checks++; if (level !== 5'b0 || press !== 5'b0) begin n_fail++; $display("FAIL idle_after_reset: level %b press %b expected 00000", level, press); end
    $display("test_reset done");
  endtask

  task automatic test_single_press();
    logic [4:0] e;
    raw = 5'b00001;
    for (int k = 1; k <= 7; k++) begin
      step();
      e = (k >= 6) ? 5'b00001 : 5'b00000;
      n_checks++; if (level !== e) begin n_fail++; $display("FAIL press_level edge %0d: got %b expected %b", k, level, e); end
      e = (k == 6) ? 5'b00001 : 5'b00000;
      n_checks++; if (press !== e) begin n_fail++; $display("FAIL press_pulse edge %0d: got %b expected %b", k, press, e); end
    end
    n_checks++; if (sticky !== (5'b00001 & SMASK)) begin n_fail++; $display("FAIL press_sticky: got %b expected %b", sticky, 5'b00001 & SMASK); end
    n_checks++; if (irq !== SMASK[0]) begin n_fail++; $display("FAIL press_irq: got %b expected %b", irq, SMASK[0]); end
    raw = 5'b00000;
    for (int k = 1; k <= 7; k++) begin
      step();
      e = (k >= 6) ? 5'b00000 : 5'b00001;
      n_checks++; if (level !== e) begin n_fail++; $display("FAIL release_level edge %0d: got %b expected %b", k, level, e); end
      e = (k == 6) ? 5'b00001 : 5'b00000;
      n_checks++; if (rel !== e) begin n_fail++; $display("FAIL release_pulse edge %0d: got %b expected %b", k, rel, e); end
    end
    n_checks++; if (sticky !== (5'b00001 & SMASK)) begin n_fail++; $display("FAIL sticky_hold: got %b expected %b", sticky, 5'b00001 & SMASK); end
    $display("test_single_press done");
  endtask

  task automatic test_clear();
    clr = 5'b00001;
    step();
    clr = 5'b00000;
    n_checks++; if (sticky !== 5'b0) begin n_fail++; $display("FAIL clear_sticky: got %b expected 00000", sticky); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL clear_irq: got %b expected 0", irq); end
    raw = 5'b00001;
    repeat (5) step();
    clr = 5'b00001;
    step();
    clr = 5'b00000;
    n_checks++; if (press !== 5'b00001) begin n_fail++; $display("FAIL coincide_press: got %b expected 00001", press); end
    n_checks++; if (sticky !== (5'b00001 & SMASK)) begin n_fail++; $display("FAIL coincide_sticky: got %b expected %b", sticky, 5'b00001 & SMASK); end
    step();
    n_checks++; if (irq !== SMASK[0]) begin n_fail++; $display("FAIL coincide_irq: got %b expected %b", irq, SMASK[0]); end
    raw = 5'b00000;
    repeat (7) step();
    clr = 5'b00001;
    step();
    clr = 5'b00000;
    n_checks++; if (sticky !== 5'b0) begin n_fail++; $display("FAIL clear_again: got %b expected 00000", sticky); end
    $display("test_clear done");
  endtask

  task automatic test_glitch();
    raw = 5'b00010;
    repeat (3) step();
    raw = 5'b00000;
    for (int k = 4; k <= 12; k++) begin
      step();
      n_checks++; if (level !== 5'b0 || press !== 5'b0) begin n_fail++; $display("FAIL glitch edge %0d: level %b press %b expected 00000", k, level, press); end
    end
    n_checks++; if (sticky !== 5'b0) begin n_fail++; $display("FAIL glitch_sticky: got %b expected 00000", sticky); end
    $display("test_glitch done");
  endtask

  task automatic test_simultaneous();
    logic [4:0] e;
    raw = 5'b10100;
    for (int k = 1; k <= 7; k++) begin
      step();
      e = (k == 6) ? 5'b10100 : 5'b00000;
      n_checks++; if (press !== e) begin n_fail++; $display("FAIL multi_press edge %0d: got %b expected %b", k, press, e); end
    end
    n_checks++; if (level !== 5'b10100) begin n_fail++; $display("FAIL multi_level: got %b expected 10100", level); end
    raw = 5'b00000;
    for (int k = 1; k <= 7; k++) begin
      step();
      e = (k == 6) ? 5'b10100 : 5'b00000;
      n_checks++; if (rel !== e) begin n_fail++; $display("FAIL multi_release edge %0d: got %b expected %b", k, rel, e); end
    end
    n_checks++; if (sticky !== (5'b10100 & SMASK)) begin n_fail++; $display("FAIL multi_sticky: got %b expected %b", sticky, 5'b10100 & SMASK); end
    clr = 5'b10100;
    step();
    clr = 5'b00000;
    n_checks++; if (sticky !== 5'b0 || irq !== 1'b0) begin n_fail++; $display("FAIL multi_clear: sticky %b irq %b expected 00000/0", sticky, irq); end
    $display("test_simultaneous done");
  endtask

  task automatic test_reset_mid();
    logic [4:0] e;
    raw = 5'b00001;
    repeat (6) step();
    raw = 5'b01001;
    repeat (3) step();
    #2 rstn = 1'b0;
    #1;
    n_checks++; if (level !== 5'b0) begin n_fail++; $display("FAIL midreset_level: got %b expected 00000", level); end
    n_checks++; if (sticky !== 5'b0 || irq !== 1'b0) begin n_fail++; $display("FAIL midreset_sticky: sticky %b irq %b expected 00000/0", sticky, irq); end
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      e = (k >= 6) ? 5'b01001 : 5'b00000;
      n_checks++; if (level !== e) begin n_fail++; $display("FAIL midreset_relevel edge %0d: got %b expected %b", k, level, e); end
      e = (k == 6) ? 5'b01001 : 5'b00000;
      n_checks++; if (press !== e) begin n_fail++; $display("FAIL midreset_press edge %0d: got %b expected %b", k, press, e); end
    end
    raw = 5'b00000;
    repeat (7) step();
    clr = 5'b01001;
    step();
    clr = 5'b00000;
    n_checks++; if (sticky !== 5'b0) begin n_fail++; $display("FAIL midreset_clear: got %b expected 00000", sticky); end
    $display("test_reset_mid done");
  endtask

  task automatic test_active_low();
    logic [4:0] e;
    raw_n = 5'b11110;
    for (int k = 1; k <= 7; k++) begin
      step();
      e = (k >= 6) ? 5'b00001 : 5'b00000;
      n_checks++; if (level_n !== e) begin n_fail++; $display("FAIL alow_level edge %0d: got %b expected %b", k, level_n, e); end
      e = (k == 6) ? 5'b00001 : 5'b00000;
      n_checks++; if (press_n !== e) begin n_fail++; $display("FAIL alow_press edge %0d: got %b expected %b", k, press_n, e); end
    end
    n_checks++; if (sticky_n !== (5'b00001 & SMASK)) begin n_fail++; $display("FAIL alow_sticky: got %b expected %b", sticky_n, 5'b00001 & SMASK); end
    n_checks++; if (irq_n !== SMASK[0]) begin n_fail++; $display("FAIL alow_irq: got %b expected %b", irq_n, SMASK[0]); end
    $display("test_active_low done");
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rstn  = 1'b0;
    raw   = 5'b00000;
    clr   = 5'b00000;
    raw_n = 5'b11111;
    clr_n = 5'b00000;
    test_reset();
    test_single_press();
    test_clear();
    test_glitch();
    test_simultaneous();
    test_reset_mid();
    test_active_low();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
